// File: rtl/car_signal_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | car_signal_fsm_if                                                    |
// | Pedestrian/maintenance inputs and car-light code outputs.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface car_signal_fsm_if;
  logic       buttonPress;
  logic       maintenance;
  logic [1:0] fsmCarControl;
  logic       pedWalk;
  logic       requestPending;

  modport master (
    input  buttonPress,
    input  maintenance,
    output fsmCarControl,
    output pedWalk,
    output requestPending
  );

  modport slave (
    output buttonPress,
    output maintenance,
    input  fsmCarControl,
    input  pedWalk,
    input  requestPending
  );
endinterface
`default_nettype wire

// File: rtl/car_signal_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | car_signal_fsm                                                       |
// | Timed green/yellow/red car light sequencer with pedestrian requests  |
// | and a maintenance flash mode.                                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module car_signal_fsm #(
  parameter int TICK_DIV    = 4,
  parameter int GREEN_TIME  = 6,
  parameter int MIN_GREEN   = 2,
  parameter int YELLOW_TIME = 2,
  parameter int RED_TIME    = 3
) (
  input  wire logic        clk,
  input  wire logic        reset,
  car_signal_fsm_if.master bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] c_tickLast   = PW'(TICK_DIV - 1);
  localparam logic [7:0]    c_redLast    = 8'(RED_TIME - 1);
  localparam logic [7:0]    c_greenLast  = 8'(GREEN_TIME - 1);
  localparam logic [7:0]    c_minGreen   = 8'(MIN_GREEN - 1);
  localparam logic [7:0]    c_yellowLast = 8'(YELLOW_TIME - 1);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [PW-1:0] r_prescale;
  logic [7:0]    r_timer;
  logic          r_request;
  logic          r_pedWalk;
  logic          w_tick;
  logic          w_change;

  assign w_tick   = (r_prescale == c_tickLast);
  assign w_change = (w_nextState != r_state);

  always_comb begin
    w_nextState = r_state;
    if (bus.maintenance) begin
      w_nextState = ST_FLASH;
    end else begin
      unique case (r_state)
        ST_RED:
          if (w_tick && r_timer == c_redLast) w_nextState = ST_GREEN;
        ST_GREEN:
          if (w_tick && (r_timer == c_greenLast ||
                         (r_request && r_timer >= c_minGreen)))
            w_nextState = ST_YELLOW;
        ST_YELLOW:
          if (w_tick && r_timer == c_yellowLast) w_nextState = ST_RED;
        ST_FLASH:
          w_nextState = ST_RED;
        default:
          w_nextState = ST_RED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RED;
      r_prescale <= '0;
      r_timer    <= '0;
      r_request  <= 1'b0;
      r_pedWalk  <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_pedWalk <= (w_nextState == ST_RED);

      // Every phase starts on a fresh tick boundary.
      if (w_change) begin
        r_prescale <= '0;
        r_timer    <= '0;
      end else begin
        r_prescale <= w_tick ? '0 : r_prescale + PW'(1);
        if (w_tick && r_timer != 8'hFF) r_timer <= r_timer + 8'd1;
      end

      // Clearing on RED/FLASH entry takes priority over a coincident press.
      if ((w_change && w_nextState == ST_RED) || w_nextState == ST_FLASH)
        r_request <= 1'b0;
      else if (bus.buttonPress && (r_state == ST_GREEN || r_state == ST_YELLOW))
        r_request <= 1'b1;
    end
  end

  assign bus.fsmCarControl  = r_state;
  assign bus.pedWalk        = r_pedWalk;
  assign bus.requestPending = r_request;

endmodule
`default_nettype wire

// File: tb/tb_car_signal_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_car_signal_fsm                                                    |
// | Table vectors, corner sequences and random stimulus vs a model.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_car_signal_fsm;
  localparam int TICK_DIV    = 4;
  localparam int GREEN_TIME  = 6;
  localparam int MIN_GREEN   = 2;
  localparam int YELLOW_TIME = 2;
  localparam int RED_TIME    = 3;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] leds;

  car_signal_fsm_if busIf ();

  car_signal_fsm #(
    .TICK_DIV(TICK_DIV), .GREEN_TIME(GREEN_TIME), .MIN_GREEN(MIN_GREEN),
    .YELLOW_TIME(YELLOW_TIME), .RED_TIME(RED_TIME)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (busIf)
  );

  always #5 clk = ~clk;

  // Downstream LED decoder fed by the controller code.
  assign leds = 4'b0001 << busIf.fsmCarControl;

  int nVec = 0;
  int nErr = 0;

  // Model: phase code, clocks spent in the phase, latched request.
  logic [1:0] mPhase;
  int         mElapsed;
  logic       mReq;

  typedef struct {
    logic       press;
    logic       maint;
    int         cycles;
    logic [1:0] expCode;
    logic       expWalk;
    logic       expReq;
  } vec_t;

  vec_t tbl [17];

  task automatic modelReset();
    mPhase = 2'd0; mElapsed = 0; mReq = 1'b0;
  endtask

  task automatic modelStep(input logic press, input logic maint);
    int n;
    logic [1:0] nxt;
    n   = mElapsed + 1;
    nxt = mPhase;
    if (maint) nxt = 2'd3;
    else begin
      case (mPhase)
        2'd0: if (n == RED_TIME * TICK_DIV) nxt = 2'd1;
        2'd1: if (n == GREEN_TIME * TICK_DIV ||
                  (mReq && n % TICK_DIV == 0 && n / TICK_DIV >= MIN_GREEN)) nxt = 2'd2;
        2'd2: if (n == YELLOW_TIME * TICK_DIV) nxt = 2'd0;
        default: nxt = 2'd0;
      endcase
    end
    if ((nxt == 2'd0 && mPhase != 2'd0) || nxt == 2'd3) mReq = 1'b0;
    else if (press && (mPhase == 2'd1 || mPhase == 2'd2)) mReq = 1'b1;
    mElapsed = (nxt != mPhase) ? 0 : n;
    mPhase   = nxt;
  endtask

  task automatic checkOut(input string name, input logic [1:0] expCode,
                          input logic expWalk, input logic expReq);
    nVec++;
    if (busIf.fsmCarControl !== expCode || busIf.pedWalk !== expWalk ||
        busIf.requestPending !== expReq || leds !== (4'b0001 << expCode)) begin
      nErr++;
      $display("FAIL %s @%0t: code/walk/req/leds got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b",
               name, $time, busIf.fsmCarControl, busIf.pedWalk, busIf.requestPending,
               leds, expCode, expWalk, expReq, 4'b0001 << expCode);
    end
  endtask

  task automatic step(input logic press, input logic maint);
    busIf.buttonPress = press;
    busIf.maintenance = maint;
    @(posedge clk);
    modelStep(press, maint);
    #1;
    checkOut("model", mPhase, mPhase == 2'd0, mReq);
  endtask

  task automatic waitPhase(input logic [1:0] ph);
    for (int i = 0; i < 200 && mPhase != ph; i++) step(1'b0, 1'b0);
    nVec++;
    if (mPhase != ph) begin
      nErr++;
      $display("FAIL waitPhase: phase got %0d want %0d", mPhase, ph);
    end
  endtask

  initial begin
    int maintHold;
    logic p, m;

    tbl[0]  = '{1'b0, 1'b0, 11, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0,  1, 2'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0,  1, 2'd1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0,  6, 2'd1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0,  1, 2'd2, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0,  7, 2'd2, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0,  1, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 11, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0,  1, 2'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0,  1, 2'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1,  1, 2'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 20, 2'd3, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0,  1, 2'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 11, 2'd0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0,  1, 2'd1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 23, 2'd1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0,  1, 2'd2, 1'b0, 1'b0};

    reset = 1'b1;
    busIf.buttonPress = 1'b0;
    busIf.maintenance = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOut("reset", 2'd0, 1'b1, 1'b0);
    #2 reset = 1'b0;

    for (int v = 0; v < 17; v++) begin
      for (int c = 0; c < tbl[v].cycles; c++) step(tbl[v].press, tbl[v].maint);
      checkOut($sformatf("table%0d", v), tbl[v].expCode, tbl[v].expWalk, tbl[v].expReq);
    end

    // Async reset mid-GREEN, between edges.
    waitPhase(2'd1);
    repeat (5) step(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOut("asyncReset", 2'd0, 1'b1, 1'b0);
    #2 reset = 1'b0;
    repeat (11) step(1'b0, 1'b0);
    checkOut("redAfterReset", 2'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    checkOut("greenAfterReset", 2'd1, 1'b0, 1'b0);

    // Late request does not shorten GREEN.
    repeat (19) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    checkOut("lateReqGreen", 2'd1, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    checkOut("lateReqYellow", 2'd2, 1'b0, 1'b1);

    // Maintenance raised mid-YELLOW.
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checkOut("flashEnter", 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 49; i++) step(1'($urandom_range(0, 1)), 1'b1);
    checkOut("flashHold", 2'd3, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    checkOut("flashExit", 2'd0, 1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checkOut("greenAfterFlash", 2'd1, 1'b0, 1'b0);

    // Random traffic with occasional maintenance bursts.
    maintHold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (maintHold > 0) begin
        m = 1'b1;
        maintHold--;
      end else begin
        m = 1'b0;
        if ($urandom_range(0, 299) == 0) maintHold = $urandom_range(1, 30);
      end
      p = ($urandom_range(0, 7) == 0);
      step(p, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
`default_nettype wire
